mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port word memory between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write).
- Accepts one request per cycle from either port and drives the memory control signals in the same cycle.
- Tracks the single in-flight access and routes the memory's registered read data back to the owning port one cycle later.
- Sits between the core's fetch and LSU stages and the memory instance.

Parameters:
- ADDR_W, 8, memory word-address width; the memory holds 2^ADDR_W 32-bit words.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  IF read request
- if_req_ready  out  1  IF request accepted this cycle
- if_addr  in  32  IF byte address
- if_rsp_valid  out  1  IF response strobe
- if_rsp_data  out  32  IF read data
- if_rsp_err  out  1  IF access error
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_we  in  1  1=store, 0=load
- ls_addr  in  32  LS byte address
- ls_wdata  in  32  store data, lanes pre-positioned
- ls_mask  in  4  byte-lane write enables
- ls_rsp_valid  out  1  LS response strobe
- ls_rsp_data  out  32  LS load data
- ls_rsp_err  out  1  LS access error
- mem_request  out  1  memory access strobe
- mem_we_re  out  1  1=write, 0=read
- mem_address  out  ADDR_W  word address
- mem_data_in  out  32  write data
- mem_mask  out  4  byte write enables
- mem_data_out  in  32  memory read data, registered, valid the cycle after a read

Behaviour:
- Handshake: a request transfers when valid&ready are high in the same cycle. Requesters hold valid and payload stable until ready. Ready is combinational from the valids and the rr pointer only.
- Arbitration: if exactly one valid, that port wins. If both are valid, the port not granted at the last conflict wins.
  - rr pointer: 1 bit, updated only on a conflict cycle. Reset value favours LS.
  - Never assert both readys in one cycle.
- Issue (same cycle as acceptance):
  - mem_request=1 unless the request is errored.
  - mem_we_re = ls_we for LS, 0 for IF.
  - mem_address = addr[ADDR_W+1:2].
  - mem_data_in = ls_wdata and mem_mask = ls_mask for LS. Both are 0 for IF.
  - When nothing is accepted, all mem_* outputs are 0.
- Errors:
  - A request is errored if addr[31:ADDR_W+2] != 0.
  - An IF request is also errored if if_addr[1:0] != 0.
  - LS addr[1:0] is ignored.
  - An errored request is accepted but not issued to memory.
- Pending register (pend_valid, pend_port, pend_write, pend_err) loads on every acceptance and clears otherwise. This gives one response per acceptance, exactly one cycle later.
- Response cycle:
  - <port>_rsp_valid = pend_valid & (pend_port matches).
  - rsp_data = mem_data_out for a non-error read, otherwise 0.
  - rsp_err = pend_err.
  - No response backpressure; requesters must sink every response.
- Throughput: a new request may be accepted in the response cycle of the previous one, giving one access per cycle. A store accepted in cycle t is visible to a read accepted in cycle t+1.
- Reset (async assert, sync release): pend_* and rr clear and all rsp_valid go 0 immediately. An access in flight when reset asserts produces no response.
- Reset values: all readys, rsp_valid, rsp_err, rsp_data and mem_* outputs are 0.

Test Plan:
- IF only, if_addr=0x10 with mem word 4 = 0xDEADBEEF -> mem_address=4 and mem_request=1 in cycle t; if_rsp_valid=1 with data 0xDEADBEEF in t+1.
- LS store 0x11223344, mask 4'b0011, addr 0x20, followed next cycle by an LS load from 0x20 (word previously 0) -> load rsp_data=0x00003344; store rsp_valid=1 with data 0.
- Both valid for 4 consecutive cycles, starting after reset -> grants LS, IF, LS, IF; responses alternate with correct data; never both readys high.
- IF addr 0x402 (misaligned) and LS addr 0x400 (out of range for ADDR_W=8) -> mem_request=0 for both; rsp_err=1 and rsp_data=0 the next cycle.
- rst_n asserted in the cycle after an IF acceptance -> if_rsp_valid stays 0; after release the first conflict grants LS.
- Back-to-back IF reads of words 0..7 -> one acceptance per cycle, 8 responses in order with matching data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port word memory between the instruction-fetch (read-only)
// and load/store requesters, issuing in the accept cycle and routing the response one cycle later.
module mem_port_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,

  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [3:0]        ls_mask,
  output logic              ls_rsp_valid,
  output logic [31:0]       ls_rsp_data,
  output logic              ls_rsp_err,

  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_data_out
);

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  // Round-robin pointer: 1 means IF wins the next conflict, so reset favours LS.
  logic  r_rr_if;
  logic  r_pend_valid;
  port_e r_pend_port;
  logic  r_pend_write;
  logic  r_pend_err;

  logic  w_conflict;
  logic  w_if_grant;
  logic  w_ls_grant;
  logic  w_if_err;
  logic  w_ls_err;
  logic  w_rd_ok;
  logic  w_unused_ls_lsb;

  // Readys depend only on the valids and the pointer; rst_n masks them so nothing
  // is accepted or issued while the block is held in reset.
  assign w_conflict = if_req_valid & ls_req_valid;
  assign w_if_grant = rst_n & if_req_valid & (~ls_req_valid | r_rr_if);
  assign w_ls_grant = rst_n & ls_req_valid & (~if_req_valid | ~r_rr_if);

  assign if_req_ready = w_if_grant;
  assign ls_req_ready = w_ls_grant;

  assign w_if_err = (|if_addr[31:ADDR_W+2]) | (|if_addr[1:0]);
  assign w_ls_err = |ls_addr[31:ADDR_W+2];

  // LS byte-offset bits are meaningless to a word memory; lanes come via the mask.
  assign w_unused_ls_lsb = ^ls_addr[1:0];

  // NOTE: every output gets a default first so no path through the block leaves a latch.
  always_comb begin
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    mem_mask    = '0;
    if (w_ls_grant && !w_ls_err) begin
      mem_request = 1'b1;
      mem_we_re   = ls_we;
      mem_address = ls_addr[ADDR_W+1:2];
      mem_data_in = ls_wdata;
      mem_mask    = ls_mask;
    end else if (w_if_grant && !w_if_err) begin
      mem_request = 1'b1;
      mem_address = if_addr[ADDR_W+1:2];
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_if      <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_port  <= PORT_IF;
      r_pend_write <= 1'b0;
      r_pend_err   <= 1'b0;
    end else begin
      r_pend_valid <= w_if_grant | w_ls_grant;
      r_pend_port  <= w_ls_grant ? PORT_LS : PORT_IF;
      r_pend_write <= w_ls_grant & ls_we;
      r_pend_err   <= w_ls_grant ? w_ls_err : (w_if_grant & w_if_err);
      if (w_conflict) begin
        r_rr_if <= ~r_rr_if;
      end
    end
  end

  // Only a successful read carries memory data; stores and errors return zero.
  assign w_rd_ok = r_pend_valid & ~r_pend_write & ~r_pend_err;

  assign if_rsp_valid = r_pend_valid & (r_pend_port == PORT_IF);
  assign ls_rsp_valid = r_pend_valid & (r_pend_port == PORT_LS);

  assign if_rsp_data  = (if_rsp_valid & w_rd_ok) ? mem_data_out : 32'h0;
  assign ls_rsp_data  = (ls_rsp_valid & w_rd_ok) ? mem_data_out : 32'h0;

  assign if_rsp_err   = if_rsp_valid & r_pend_err;
  assign ls_rsp_err   = ls_rsp_valid & r_pend_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory, reference shadow
// memory and a response scoreboard filled at acceptance and drained on responses.
module tb_mem_port_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_valid, if_req_ready;
  logic [31:0]   if_addr;
  logic          if_rsp_valid, if_rsp_err;
  logic [31:0]   if_rsp_data;
  logic          ls_req_valid, ls_req_ready, ls_we;
  logic [31:0]   ls_addr, ls_wdata;
  logic [3:0]    ls_mask;
  logic          ls_rsp_valid, ls_rsp_err;
  logic [31:0]   ls_rsp_data;
  logic          mem_request, mem_we_re;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data_in, mem_data_out;
  logic [3:0]    mem_mask;

  mem_port_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_mask(ls_mask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .ls_rsp_err(ls_rsp_err),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_mask(mem_mask), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Power-up content of every word; a word reads this until first written.
  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'h0;
    return 32'hA000_0000 | (i * 32'h0001_0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port memory with registered read data.
  logic [31:0] mem_q [256];
  logic        mem_wr [256];
  always @(posedge clk) begin
    if (mem_request) begin
      if (mem_we_re) begin
        mem_q[mem_address]  <= merge(mem_wr[mem_address] ? mem_q[mem_address]
                                     : init_word(int'(mem_address)), mem_data_in, mem_mask);
        mem_wr[mem_address] <= 1'b1;
      end else begin
        mem_data_out <= mem_wr[mem_address] ? mem_q[mem_address] : init_word(int'(mem_address));
      end
    end
  end

  // Reference shadow used only by the bench to derive expected read data.
  logic [31:0] sh_q  [256];
  logic        sh_wr [256];

  typedef struct {
    bit          port;   // 0 = IF, 1 = LS
    logic [31:0] data;
    bit          err;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   m_rr_if  = 1'b0;

  logic          obs_if_ready, obs_ls_ready, obs_mem_request;
  logic [AW-1:0] obs_mem_address;
  logic          obs_if_rsp_valid, obs_ls_rsp_valid, obs_if_rsp_err, obs_ls_rsp_err;
  logic [31:0]   obs_if_rsp_data, obs_ls_rsp_data;

  task automatic check_rsp();
    rsp_t e;
    obs_if_rsp_valid = if_rsp_valid; obs_if_rsp_data = if_rsp_data; obs_if_rsp_err = if_rsp_err;
    obs_ls_rsp_valid = ls_rsp_valid; obs_ls_rsp_data = ls_rsp_data; obs_ls_rsp_err = ls_rsp_err;
    n_checks++;
    if (sb.size() == 0) begin
      if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious_rsp: if_rsp_valid=%b ls_rsp_valid=%b, required 0/0",
                 if_rsp_valid, ls_rsp_valid);
      end
    end else begin
      e = sb.pop_front();
      if (e.port) begin
        if ({ls_rsp_valid, ls_rsp_err, ls_rsp_data, if_rsp_valid} !== {1'b1, e.err, e.data, 1'b0}) begin
          n_fail++;
          $display("FAIL ls_rsp: got v=%b err=%b data=%h ifv=%b, required v=1 err=%b data=%h ifv=0",
                   ls_rsp_valid, ls_rsp_err, ls_rsp_data, if_rsp_valid, e.err, e.data);
        end
      end else begin
        if ({if_rsp_valid, if_rsp_err, if_rsp_data, ls_rsp_valid} !== {1'b1, e.err, e.data, 1'b0}) begin
          n_fail++;
          $display("FAIL if_rsp: got v=%b err=%b data=%h lsv=%b, required v=1 err=%b data=%h lsv=0",
                   if_rsp_valid, if_rsp_err, if_rsp_data, ls_rsp_valid, e.err, e.data);
        end
      end
    end
  endtask

  // One clock cycle: check the response from the previous edge, drive a new
  // request pair, check the grant and the memory issue, and record expectations.
  task automatic step(input logic iv, input logic [31:0] ia,
                      input logic lv, input logic lwe, input logic [31:0] la,
                      input logic [31:0] lwd, input logic [3:0] lm);
    logic          exp_if, exp_ls, err;
    logic [AW-1:0] w;
    rsp_t          e;
    @(negedge clk);
    check_rsp();
    if_req_valid = iv; if_addr = ia;
    ls_req_valid = lv; ls_we = lwe; ls_addr = la; ls_wdata = lwd; ls_mask = lm;
    #1;
    exp_if = iv & (~lv | m_rr_if);
    exp_ls = lv & (~iv | ~m_rr_if);
    obs_if_ready = if_req_ready; obs_ls_ready = ls_req_ready;
    obs_mem_request = mem_request; obs_mem_address = mem_address;
    n_checks++;
    if (if_req_ready !== exp_if || ls_req_ready !== exp_ls) begin
      n_fail++;
      $display("FAIL grant: if_ready=%b ls_ready=%b, required %b/%b", if_req_ready, ls_req_ready,
               exp_if, exp_ls);
    end
    n_checks++;
    if (if_req_ready === 1'b1 && ls_req_ready === 1'b1) begin
      n_fail++;
      $display("FAIL both_ready: if_ready=1 ls_ready=1, required at most one");
    end
    if (exp_ls || exp_if) begin
      err = exp_ls ? (|la[31:AW+2]) : ((|ia[31:AW+2]) | (|ia[1:0]));
      w   = exp_ls ? la[AW+1:2] : ia[AW+1:2];
      n_checks++;
      if (err) begin
        if (mem_request !== 1'b0) begin
          n_fail++;
          $display("FAIL err_issue: mem_request=%b, required 0", mem_request);
        end
      end else if ({mem_request, mem_we_re, mem_address, mem_data_in, mem_mask} !==
                   {1'b1, exp_ls & lwe, w, exp_ls ? lwd : 32'h0, exp_ls ? lm : 4'h0}) begin
        n_fail++;
        $display("FAIL issue: req=%b we=%b addr=%h din=%h mask=%h, required 1 %b %h %h %h",
                 mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
                 exp_ls & lwe, w, exp_ls ? lwd : 32'h0, exp_ls ? lm : 4'h0);
      end
      e.port = exp_ls;
      e.err  = err;
      e.data = (err || (exp_ls && lwe)) ? 32'h0 : (sh_wr[w] ? sh_q[w] : init_word(int'(w)));
      sb.push_back(e);
      if (exp_ls && lwe && !err) begin
        sh_q[w]  = merge(sh_wr[w] ? sh_q[w] : init_word(int'(w)), lwd, lm);
        sh_wr[w] = 1'b1;
      end
    end else begin
      n_checks++;
      if ({mem_request, mem_we_re, mem_address, mem_data_in, mem_mask} !== '0) begin
        n_fail++;
        $display("FAIL idle_issue: req=%b we=%b addr=%h din=%h mask=%h, required all 0",
                 mem_request, mem_we_re, mem_address, mem_data_in, mem_mask);
      end
    end
    if (iv && lv) m_rr_if = ~m_rr_if;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    m_rr_if = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    if_req_valid = 1'b1; if_addr = 32'h10;
    ls_req_valid = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'hFFFF_FFFF; ls_mask = 4'hF;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err,
         if_rsp_data, ls_rsp_data, mem_request, mem_we_re, mem_address, mem_data_in, mem_mask} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b%b rspv=%b%b err=%b%b d=%h/%h mem=%b%b%h%h%h, required all 0",
               if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err,
               if_rsp_data, ls_rsp_data, mem_request, mem_we_re, mem_address, mem_data_in, mem_mask);
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_if_read();
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++;
    if (obs_mem_request !== 1'b1 || obs_mem_address !== 8'd4) begin
      n_fail++;
      $display("FAIL if_read_issue: req=%b addr=%0d, required 1/4", obs_mem_request, obs_mem_address);
    end
    idle();
    n_checks++;
    if (obs_if_rsp_valid !== 1'b1 || obs_if_rsp_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL if_read_data: v=%b data=%h, required 1/deadbeef", obs_if_rsp_valid, obs_if_rsp_data);
    end
  endtask

  task automatic test_store_load();
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h11223344, 4'b0011);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    n_checks++;
    if (obs_ls_rsp_valid !== 1'b1 || obs_ls_rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL store_rsp: v=%b data=%h, required 1/00000000", obs_ls_rsp_valid, obs_ls_rsp_data);
    end
    idle();
    n_checks++;
    if (obs_ls_rsp_valid !== 1'b1 || obs_ls_rsp_data !== 32'h00003344) begin
      n_fail++;
      $display("FAIL load_after_store: v=%b data=%h, required 1/00003344", obs_ls_rsp_valid, obs_ls_rsp_data);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] ia [4];
    logic [31:0] la [4];
    logic [3:0]  got;
    ia = '{32'h8, 32'h8, 32'hC, 32'hC};
    la = '{32'h14, 32'h18, 32'h18, 32'h1C};
    apply_reset();
    got = '0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ia[i], 1'b1, 1'b0, la[i], 32'h0, 4'h0);
      got[i] = obs_ls_ready;
    end
    idle();
    n_checks++;
    if (got !== 4'b0101) begin
      n_fail++;
      $display("FAIL conflict_order: ls grant pattern (cycle3..0)=%b, required 0101", got);
    end
    idle();
  endtask

  task automatic test_errors();
    step(1'b1, 32'h402, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++;
    if (obs_if_ready !== 1'b1 || obs_mem_request !== 1'b0) begin
      n_fail++;
      $display("FAIL if_err_issue: ready=%b req=%b, required 1/0", obs_if_ready, obs_mem_request);
    end
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF);
    n_checks++;
    if (obs_if_rsp_err !== 1'b1 || obs_if_rsp_data !== 32'h0 || obs_mem_request !== 1'b0) begin
      n_fail++;
      $display("FAIL if_err_rsp: err=%b data=%h ls_req=%b, required 1/0/0",
               obs_if_rsp_err, obs_if_rsp_data, obs_mem_request);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    idle();
    n_checks++;
    if (obs_ls_rsp_err !== 1'b1 || obs_ls_rsp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL ls_err_rsp: err=%b data=%h, required 1/0", obs_ls_rsp_err, obs_ls_rsp_data);
    end
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 32'h10, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_rsp: if_rsp_valid=%b ls_rsp_valid=%b, required 0/0", if_rsp_valid, ls_rsp_valid);
    end
    sb.delete();
    m_rr_if = 1'b0;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    n_checks++;
    if (obs_ls_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_conflict: ls_ready=%b, required 1", obs_ls_ready);
    end
    idle();
    idle();
  endtask

  task automatic test_back_to_back();
    int accepted;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      if (obs_if_ready === 1'b1) accepted++;
    end
    idle();
    n_checks++;
    if (accepted != 8) begin
      n_fail++;
      $display("FAIL back_to_back_accepts: %0d accepted, required 8", accepted);
    end
  endtask

  task automatic test_random();
    bit          pi, pl, pwe;
    logic [31:0] ia, la, wd;
    logic [3:0]  m;
    pi = 0; pl = 0; pwe = 0; ia = 0; la = 0; wd = 0; m = 0;
    for (int c = 0; c < 80; c++) begin
      if (!pi && $urandom_range(0, 2) != 0) begin
        pi = 1;
        ia = {22'h0, 6'($urandom_range(0, 15)), 2'b00};
        if ($urandom_range(0, 7) == 0) ia[1] = 1'b1;
        if ($urandom_range(0, 7) == 0) ia[20] = 1'b1;
      end
      if (!pl && $urandom_range(0, 2) != 0) begin
        pl  = 1;
        pwe = 1'($urandom_range(0, 1));
        la  = {22'h0, 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) la[15] = 1'b1;
        wd  = $urandom;
        m   = 4'($urandom_range(0, 15));
      end
      step(pi, ia, pl, pwe, la, wd, m);
      if (obs_if_ready === 1'b1) pi = 0;
      if (obs_ls_ready === 1'b1) pl = 0;
    end
    idle();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      sh_wr[i] = 1'b0;
      sh_q[i]  = 32'h0;
    end
    if_req_valid = 1'b0; if_addr = 32'h0;
    ls_req_valid = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_mask = 4'h0;
    test_reset();
    test_if_read();
    test_store_load();
    test_conflict();
    test_errors();
    test_reset_inflight();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_wr[i] = 1'b0;
  end

endmodule
